// File: rtl/qspi_cmd_pkg.sv
// Shared QSPI command definitions: abstract command indices, vendor opcode
// tables, flash-type / lane-mode encodings and decoder state encoding.
// The opcode tables are shared with the command parser so both directions
// of the mapping always agree.
package qspi_cmd_pkg;

  localparam int CMD_IDX_W = 5;
  localparam int OPCODE_W  = 8;
  localparam int NUM_CMDS  = 22;

  localparam logic [CMD_IDX_W-1:0] CMD_UNKNOWN = 5'h1F;

  typedef enum logic [CMD_IDX_W-1:0] {
    CMD_READ                         = 5'd0,
    CMD_FAST_READ                    = 5'd1,
    CMD_DUAL_OUTPUT_READ             = 5'd2,
    CMD_QUAD_OUTPUT_READ             = 5'd3,
    CMD_DUAL_IO_READ                 = 5'd4,
    CMD_QUAD_IO_READ                 = 5'd5,
    CMD_WORD_READ                    = 5'd6,
    CMD_PAGE_PROGRAM                 = 5'd7,
    CMD_QUAD_PAGE_PROGRAM            = 5'd8,
    CMD_SECTOR_ERASE                 = 5'd9,
    CMD_BLOCK_ERASE_32K              = 5'd10,
    CMD_BLOCK_ERASE_64K              = 5'd11,
    CMD_CHIP_ERASE                   = 5'd12,
    CMD_WRITE_ENABLE                 = 5'd13,
    CMD_WRITE_DISABLE                = 5'd14,
    CMD_READ_STATUS_REGISTER         = 5'd15,
    CMD_WRITE_STATUS_REGISTER        = 5'd16,
    CMD_READ_JEDEC_ID                = 5'd17,
    CMD_ENABLE_RESET                 = 5'd18,
    CMD_RESET_DEVICE                 = 5'd19,
    CMD_DEEP_POWER_DOWN              = 5'd20,
    CMD_RELEASE_FROM_DEEP_POWER_DOWN = 5'd21
  } cmd_e;

  typedef enum logic [1:0] {
    FLASH_MICRON   = 2'b00,
    FLASH_WINBOND  = 2'b01,
    FLASH_INFINEON = 2'b10,
    FLASH_RESERVED = 2'b11
  } flash_type_e;

  typedef enum logic [1:0] {
    LANE_SINGLE   = 2'b00,
    LANE_DUAL     = 2'b01,
    LANE_QUAD     = 2'b10,
    LANE_RESERVED = 2'b11
  } lane_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOOKUP,
    ST_HOLD,
    ST_DISCARD
  } dec_state_e;

  // Micron has no word read; it aliases Quad IO Read so index 5 must win.
  localparam logic [OPCODE_W-1:0] MICRON_OPC [NUM_CMDS] = '{
    8'h03, 8'h0B, 8'h3B, 8'h6B, 8'hBB, 8'hEB, 8'hEB, 8'h02,
    8'h32, 8'h20, 8'h52, 8'hD8, 8'hC7, 8'h06, 8'h04, 8'h05,
    8'h01, 8'h9F, 8'h66, 8'h99, 8'hB9, 8'hAB};

  localparam logic [OPCODE_W-1:0] WINBOND_OPC [NUM_CMDS] = '{
    8'h03, 8'h0B, 8'h3B, 8'h6B, 8'hBB, 8'hEB, 8'hE7, 8'h02,
    8'h32, 8'h20, 8'h52, 8'hD8, 8'hC7, 8'h06, 8'h04, 8'h05,
    8'h01, 8'h9F, 8'h66, 8'h99, 8'hB9, 8'hAB};

  localparam logic [OPCODE_W-1:0] INFINEON_OPC [NUM_CMDS] = '{
    8'h03, 8'h0B, 8'h3B, 8'h6B, 8'hBB, 8'hEB, 8'hE7, 8'h02,
    8'h32, 8'h20, 8'h52, 8'hD8, 8'h60, 8'h06, 8'h04, 8'h05,
    8'h01, 8'h9F, 8'h66, 8'hF0, 8'hB9, 8'hAB};

  // Forward map (vendor, command index) -> opcode; reserved vendor has no table.
  function automatic logic [OPCODE_W-1:0] vendor_opcode(
    input logic [1:0] flash_type,
    input int         idx
  );
    logic [OPCODE_W-1:0] opc;
    opc = '0;
    case (flash_type)
      FLASH_MICRON:   opc = MICRON_OPC[idx];
      FLASH_WINBOND:  opc = WINBOND_OPC[idx];
      FLASH_INFINEON: opc = INFINEON_OPC[idx];
      default:        opc = '0;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/opcode_lookup.sv
// Combinational reverse lookup: (flash type, opcode) -> abstract command.
// When several indices share an opcode the lowest index is reported.
module opcode_lookup
  import qspi_cmd_pkg::*;
(
  input  logic [1:0]           flash_type_i,
  input  logic [OPCODE_W-1:0]  opcode_i,
  output logic [CMD_IDX_W-1:0] cmd_o,
  output logic                 unknown_o
);

  // Scan from the highest index down so the lowest matching index overrides.
  always_comb begin
    cmd_o     = CMD_UNKNOWN;
    unknown_o = 1'b1;
    if (flash_type_i != FLASH_RESERVED) begin
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
        if (vendor_opcode(flash_type_i, i) == opcode_i) begin
          cmd_o     = CMD_IDX_W'(i);
          unknown_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/command_decoder.sv
// Flash-side QSPI opcode decoder: deserializes the 8-bit opcode phase in
// single/dual/quad mode, reverse-maps it to the abstract command index and
// offers it on a valid/ready handshake.
// Optional macro CMD_ERR_CNT_EN adds a saturating unknown-opcode counter.
module command_decoder
  import qspi_cmd_pkg::*;
#(
  parameter int CMD_W     = 5,
  parameter int OPC_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_n_i,
  input  logic                 sample_en_i,
  input  logic [3:0]           io_i,
  input  logic [1:0]           lane_mode_i,
  input  logic [1:0]           flash_type_i,
  output logic [CMD_W-1:0]     cmd_o,
  output logic [OPC_W-1:0]     opcode_o,
  output logic                 unknown_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic                 frame_abort_o,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  dec_state_e       state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [1:0]       ft_q, ft_d;
  logic [1:0]       lm_q, lm_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             unk_q, unk_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic             busy_q;

  logic [CMD_IDX_W-1:0] lkCmd;
  logic                 lkUnk;

  opcode_lookup u_lookup (
    .flash_type_i (ft_q),
    .opcode_i     (shreg_q),
    .cmd_o        (lkCmd),
    .unknown_o    (lkUnk)
  );

  // Next-state logic: frame sequencing, opcode shifting and result capture.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    ft_d     = ft_q;
    lm_d     = lm_q;
    cmd_d    = cmd_q;
    opc_d    = opc_q;
    unk_d    = unk_q;
    valid_d  = valid_q;
    abort_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        shreg_d  = '0;
        bitcnt_d = '0;
        if (!cs_n_i) begin
          state_d = ST_SHIFT;
          ft_d    = flash_type_i;
          lm_d    = lane_mode_i;
        end
      end
      ST_SHIFT: begin
        if (cs_n_i) begin
          state_d  = ST_IDLE;
          abort_d  = 1'b1;
          shreg_d  = '0;
          bitcnt_d = '0;
        end else if (sample_en_i) begin
          case (lm_q)
            LANE_DUAL: begin
              shreg_d  = {shreg_q[5:0], io_i[1:0]};
              bitcnt_d = bitcnt_q + 4'd2;
            end
            LANE_QUAD: begin
              shreg_d  = {shreg_q[3:0], io_i[3:0]};
              bitcnt_d = bitcnt_q + 4'd4;
            end
            default: begin
              shreg_d  = {shreg_q[6:0], io_i[0]};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          endcase
          if (bitcnt_d == 4'd8) state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cmd_d   = CMD_W'(lkCmd);
        opc_d   = OPC_W'(shreg_q);
        unk_d   = lkUnk;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (valid_q && cmd_ready_i) begin
          valid_d = 1'b0;
          state_d = cs_n_i ? ST_IDLE : ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (cs_n_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      ft_q     <= '0;
      lm_q     <= '0;
      cmd_q    <= '0;
      opc_q    <= '0;
      unk_q    <= 1'b0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      ft_q     <= ft_d;
      lm_q     <= lm_d;
      cmd_q    <= cmd_d;
      opc_q    <= opc_d;
      unk_q    <= unk_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

`ifdef CMD_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Count unknown opcodes at lookup time, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (state_q == ST_LOOKUP && lkUnk && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  assign cmd_o         = cmd_q;
  assign opcode_o      = opc_q;
  assign unknown_o     = unk_q;
  assign cmd_valid_o   = valid_q;
  assign frame_abort_o = abort_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_command_decoder.sv
// Directed self-checking bench for command_decoder.
// Honours CMD_ERR_CNT_EN when checking err_cnt_o.
module tb_command_decoder;

  localparam int CMD_W     = 5;
  localparam int OPC_W     = 8;
  localparam int ERR_CNT_W = 8;
`ifdef CMD_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cs_n_i;
  logic                 sample_en_i;
  logic [3:0]           io_i;
  logic [1:0]           lane_mode_i;
  logic [1:0]           flash_type_i;
  logic [CMD_W-1:0]     cmd_o;
  logic [OPC_W-1:0]     opcode_o;
  logic                 unknown_o;
  logic                 cmd_valid_o;
  logic                 cmd_ready_i;
  logic                 frame_abort_o;
  logic                 busy_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;

  int numAsserts = 0;
  int numFails   = 0;

  command_decoder #(.CMD_W(CMD_W), .OPC_W(OPC_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs_n_i        (cs_n_i),
    .sample_en_i   (sample_en_i),
    .io_i          (io_i),
    .lane_mode_i   (lane_mode_i),
    .flash_type_i  (flash_type_i),
    .cmd_o         (cmd_o),
    .opcode_o      (opcode_o),
    .unknown_o     (unknown_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .frame_abort_o (frame_abort_o),
    .busy_o        (busy_o),
    .err_cnt_o     (err_cnt_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    numAsserts++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic se, input logic [3:0] d);
    cs_n_i      = cs;
    sample_en_i = se;
    io_i        = d;
  endtask

  function automatic int laneWidth(input logic [1:0] lm);
    if (lm == 2'b01) return 2;
    if (lm == 2'b10) return 4;
    return 1;
  endfunction

  // Send the first n samples of byte b, MSB first, at the lane width of lm.
  task automatic shiftBits(input logic [1:0] lm, input logic [7:0] b, input int n);
    int w;
    logic [7:0] tmp;
    w = laneWidth(lm);
    for (int s = 0; s < n; s++) begin
      tmp = b >> (8 - w * (s + 1));
      tmp = tmp & 8'((1 << w) - 1);
      applyStimulus(1'b0, 1'b1, tmp[3:0]);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 4'h0);
  endtask

  // Full opcode phase; mode inputs are scrambled mid-frame to prove they were latched.
  task automatic runFrame(input logic [1:0] ft, input logic [1:0] lm, input logic [7:0] b);
    flash_type_i = ft;
    lane_mode_i  = lm;
    applyStimulus(1'b0, 1'b0, 4'h0);
    cycle();
    checkOutput("busy_in_frame", 8'(busy_o), 8'h1);
    flash_type_i = ft ^ 2'b01;
    lane_mode_i  = lm ^ 2'b11;
    shiftBits(lm, b, 8 / laneWidth(lm));
    checkOutput("valid_in_lookup", 8'(cmd_valid_o), 8'h0);
    cycle();
    checkOutput("valid_after_lookup", 8'(cmd_valid_o), 8'h1);
  endtask

  task automatic checkResult(input logic [4:0] c, input logic [7:0] o, input logic u);
    checkOutput("cmd", 8'(cmd_o), 8'(c));
    checkOutput("opcode", opcode_o, o);
    checkOutput("unknown", 8'(unknown_o), 8'(u));
  endtask

  task automatic endFrame();
    cmd_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0);
    cycle();
    checkOutput("valid_after_accept", 8'(cmd_valid_o), 8'h0);
    checkOutput("busy_after_accept", 8'(busy_o), 8'h0);
    cmd_ready_i = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd"}, 8'(cmd_o), 8'h0);
    checkOutput({tag, "_opc"}, opcode_o, 8'h0);
    checkOutput({tag, "_unk"}, 8'(unknown_o), 8'h0);
    checkOutput({tag, "_valid"}, 8'(cmd_valid_o), 8'h0);
    checkOutput({tag, "_abort"}, 8'(frame_abort_o), 8'h0);
    checkOutput({tag, "_busy"}, 8'(busy_o), 8'h0);
    checkOutput({tag, "_err"}, err_cnt_o, 8'h0);
  endtask

  initial begin
    reset        = 1'b1;
    cmd_ready_i  = 1'b0;
    lane_mode_i  = 2'b00;
    flash_type_i = 2'b00;
    applyStimulus(1'b1, 1'b0, 4'h0);
    cycle();
    cycle();
    checkAllZero("reset");
    reset = 1'b0;
    cycle();

    // Winbond dual 0xFF: unknown opcode
    runFrame(2'b01, 2'b01, 8'hFF);
    checkResult(5'h1F, 8'hFF, 1'b1);
    checkOutput("err_first", err_cnt_o, ERR_EN ? 8'h01 : 8'h00);
    endFrame();

    // Winbond single 0x03 -> Read
    runFrame(2'b01, 2'b00, 8'h03);
    checkResult(5'd0, 8'h03, 1'b0);
    endFrame();

    // Micron quad 0xEB -> Quad_IO_Read (alias with Word_Read), then DISCARD
    runFrame(2'b00, 2'b10, 8'hEB);
    checkResult(5'd5, 8'hEB, 1'b0);
    cmd_ready_i = 1'b1;
    cycle();
    cmd_ready_i = 1'b0;
    checkOutput("discard_valid", 8'(cmd_valid_o), 8'h0);
    checkOutput("discard_busy", 8'(busy_o), 8'h1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 4'(k + 3));
      cycle();
      checkOutput("discard_valid_hold", 8'(cmd_valid_o), 8'h0);
      checkOutput("discard_busy_hold", 8'(busy_o), 8'h1);
      checkOutput("discard_opc_hold", opcode_o, 8'hEB);
    end
    applyStimulus(1'b1, 1'b0, 4'h0);
    cycle();
    checkOutput("discard_exit_busy", 8'(busy_o), 8'h0);
    checkOutput("discard_exit_abort", 8'(frame_abort_o), 8'h0);

    // Abort after 5 single-lane bits, CS release wins over a 6th sample
    flash_type_i = 2'b01;
    lane_mode_i  = 2'b00;
    applyStimulus(1'b0, 1'b0, 4'h0);
    cycle();
    shiftBits(2'b00, 8'hA5, 5);
    applyStimulus(1'b1, 1'b1, 4'h1);
    cycle();
    checkOutput("abort_pulse", 8'(frame_abort_o), 8'h1);
    checkOutput("abort_busy", 8'(busy_o), 8'h0);
    checkOutput("abort_valid", 8'(cmd_valid_o), 8'h0);
    applyStimulus(1'b1, 1'b0, 4'h0);
    cycle();
    checkOutput("abort_pulse_end", 8'(frame_abort_o), 8'h0);
    checkOutput("abort_valid_end", 8'(cmd_valid_o), 8'h0);

    // Infineon dual 0x60 -> Chip_Erase, ready low 3 cycles with CS rising
    runFrame(2'b10, 2'b01, 8'h60);
    checkResult(5'd12, 8'h60, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("hold_valid", 8'(cmd_valid_o), 8'h1);
      checkOutput("hold_cmd", 8'(cmd_o), 8'd12);
      checkOutput("hold_opc", opcode_o, 8'h60);
      checkOutput("hold_abort", 8'(frame_abort_o), 8'h0);
    end
    endFrame();

    // Winbond quad 0x9F -> Read_JEDEC_ID
    runFrame(2'b01, 2'b10, 8'h9F);
    checkResult(5'd17, 8'h9F, 1'b0);
    endFrame();

    // Micron reserved lane mode behaves as single: 0xD8 -> Block_Erase_64K
    runFrame(2'b00, 2'b11, 8'hD8);
    checkResult(5'd11, 8'hD8, 1'b0);
    endFrame();

    // Reserved flash type: always unknown
    runFrame(2'b11, 2'b00, 8'h03);
    checkResult(5'h1F, 8'h03, 1'b1);
    endFrame();

    // Saturate the unknown counter
    for (int k = 0; k < 300; k++) begin
      runFrame(2'b01, 2'b10, 8'hFF);
      endFrame();
    end
    checkOutput("err_saturated", err_cnt_o, ERR_EN ? 8'hFF : 8'h00);

    // Reset mid-SHIFT after 4 bits
    flash_type_i = 2'b01;
    lane_mode_i  = 2'b00;
    applyStimulus(1'b0, 1'b0, 4'h0);
    cycle();
    shiftBits(2'b00, 8'h0B, 4);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0);
    cycle();
    checkAllZero("rst_shift");
    reset = 1'b0;
    cycle();

    // Reset mid-HOLD
    runFrame(2'b01, 2'b00, 8'h03);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0);
    cycle();
    checkAllZero("rst_hold");
    reset = 1'b0;
    cycle();

    // Recovery frame: Winbond single 0x0B -> Fast_Read
    runFrame(2'b01, 2'b00, 8'h0B);
    checkResult(5'd1, 8'h0B, 1'b0);
    endFrame();

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
